// File: rtl/ddram_bridge_pkg.sv
// Purpose: shared types and helpers for the 32-bit word <-> 64-bit DDRAM beat bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: bridge state enum, default DDR region, beat-count helper.
package ddram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_CMD  = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    // DDR region holding GPU VRAM (o_ddr_addr[28:25]).
    localparam logic [3:0] ADDR_HI_DEFAULT = 4'h3;

    // Number of 64-bit beats touched by a burst of len 32-bit words that
    // starts in the upper lane when odd is set.
    function automatic logic [7:0] beats(input logic odd, input logic [7:0] len);
        logic [8:0] sum;
        sum = 9'(odd) + 9'(len) + 9'd1;
        return sum[8:1];
    endfunction

endpackage

// File: rtl/ddram_beat_fifo.sv
// Purpose: synchronous FIFO holding 64-bit read beats until the unpacker consumes them.
// Latency: a pushed entry is visible at o_dout the cycle after the push.
// Backpressure: push is dropped when full, pop ignored when empty; push and pop may coincide.
// Ports: i_clk/i_nrst clock and async active-low reset; i_push/i_din write side;
//        i_pop/o_dout read side (o_dout is the head entry); o_full/o_empty status.
module ddram_beat_fifo #(
    parameter int DEPTH = 17,
    parameter int W     = 64
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly because DEPTH is generally not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

endmodule

// File: rtl/ddram_word_bridge.sv
// Purpose: packs 32-bit client write words into 64-bit DDRAM beats and unpacks read beats into words.
// Latency: write beat issued 1 cycle after its upper lane (or last word) is taken; read word 2 cycles after its beat.
// Backpressure: o_busy stalls the client while a write beat waits on i_ddr_busy and during whole reads.
// Ports: i_clk/i_nrst clock and async active-low reset;
//        client side i_writeEnable/i_readEnable/i_burstLength/i_targetAddr/i_data/i_byteEnable, o_busy/o_dataValid/o_data;
//        DDRAM side o_ddr_burstcnt/o_ddr_addr/o_ddr_din/o_ddr_be/o_ddr_we/o_ddr_rd, i_ddr_busy/i_ddr_dout/i_ddr_dout_ready.
module ddram_word_bridge
    import ddram_bridge_pkg::*;
#(
    parameter logic [3:0] ADDR_HI   = ADDR_HI_DEFAULT,
    parameter int         MAX_WORDS = 32
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_writeEnable,
    input  logic        i_readEnable,
    input  logic [7:0]  i_burstLength,
    input  logic [25:0] i_targetAddr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_byteEnable,
    output logic        o_busy,
    output logic        o_dataValid,
    output logic [31:0] o_data,
    output logic [7:0]  o_ddr_burstcnt,
    output logic [28:0] o_ddr_addr,
    output logic [63:0] o_ddr_din,
    output logic [7:0]  o_ddr_be,
    output logic        o_ddr_we,
    output logic        o_ddr_rd,
    input  logic        i_ddr_busy,
    input  logic [63:0] i_ddr_dout,
    input  logic        i_ddr_dout_ready
);

    localparam int FIFO_DEPTH = MAX_WORDS / 2 + 1;

    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d;              // words still to take (write) or emit (read)
    logic        wr_lane_q, wr_lane_d;      // lane of the next write word
    logic [63:0] acc_din_q, acc_din_d;      // partially filled write beat
    logic [7:0]  acc_be_q, acc_be_d;
    logic        ddr_we_q, ddr_we_d;
    logic [63:0] ddr_din_q, ddr_din_d;
    logic [7:0]  ddr_be_q, ddr_be_d;
    logic [28:0] ddr_addr_q, ddr_addr_d;
    logic [7:0]  ddr_burstcnt_q, ddr_burstcnt_d;
    logic        ddr_rd_q, ddr_rd_d;
    logic        rd_lane_q, rd_lane_d;      // lane of the FIFO head beat to emit next
    logic [31:0] data_q, data_d;
    logic        data_vld_q, data_vld_d;

    logic        busy;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [63:0] fifo_dout;

    logic        take, take_lane, take_last;
    logic [7:0]  take_rem;
    logic [63:0] base_din, din_m;
    logic [7:0]  base_be, be_m;

    ddram_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (64)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (fifo_push),
        .i_din   (i_ddr_dout),
        .i_pop   (fifo_pop),
        .o_dout  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        wr_lane_d      = wr_lane_q;
        acc_din_d      = acc_din_q;
        acc_be_d       = acc_be_q;
        ddr_we_d       = ddr_we_q;
        ddr_din_d      = ddr_din_q;
        ddr_be_d       = ddr_be_q;
        ddr_addr_d     = ddr_addr_q;
        ddr_burstcnt_d = ddr_burstcnt_q;
        ddr_rd_d       = ddr_rd_q;
        rd_lane_d      = rd_lane_q;
        data_d         = data_q;
        data_vld_d     = 1'b0;
        busy           = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        take           = 1'b0;
        take_lane      = 1'b0;
        take_last      = 1'b0;
        take_rem       = rem_q;
        base_din       = '0;
        base_be        = '0;
        din_m          = '0;
        be_m           = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_writeEnable && i_burstLength != 8'd0) begin
                    ddr_addr_d     = {ADDR_HI, i_targetAddr[25:1]};
                    ddr_burstcnt_d = beats(i_targetAddr[0], i_burstLength);
                    take           = 1'b1;
                    take_lane      = i_targetAddr[0];
                    take_last      = (i_burstLength == 8'd1);
                    take_rem       = i_burstLength - 8'd1;
                    state_d        = ST_WR;
                end else if (i_readEnable && i_burstLength != 8'd0) begin
                    ddr_addr_d     = {ADDR_HI, i_targetAddr[25:1]};
                    ddr_burstcnt_d = beats(i_targetAddr[0], i_burstLength);
                    rem_d          = i_burstLength;
                    rd_lane_d      = i_targetAddr[0];
                    ddr_rd_d       = 1'b1;
                    state_d        = ST_RD_CMD;
                end
            end

            ST_WR: begin
                busy = ddr_we_q && i_ddr_busy;
                if (ddr_we_q && !i_ddr_busy) begin
                    ddr_we_d = 1'b0;
                    // The last word always issues a beat, so rem == 0 here means the final beat is gone.
                    if (rem_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end
                end
                if (!busy && i_writeEnable && rem_q != 8'd0) begin
                    take      = 1'b1;
                    take_lane = wr_lane_q;
                    take_last = (rem_q == 8'd1);
                    take_rem  = rem_q - 8'd1;
                    base_din  = acc_din_q;
                    base_be   = acc_be_q;
                end
            end

            ST_RD_CMD: begin
                busy      = 1'b1;
                fifo_push = i_ddr_dout_ready && !fifo_full;
                if (!i_ddr_busy) begin
                    ddr_rd_d = 1'b0;
                    state_d  = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                busy      = 1'b1;
                fifo_push = i_ddr_dout_ready && !fifo_full;
                if (rem_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    data_d     = rd_lane_q ? fifo_dout[63:32] : fifo_dout[31:0];
                    data_vld_d = 1'b1;
                    // Retire the head beat after its upper lane, or early when the burst ends in its lower lane.
                    fifo_pop   = rd_lane_q || (rem_q == 8'd1);
                    rd_lane_d  = !rd_lane_q;
                    rem_d      = rem_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            if (take_lane) begin
                din_m = {i_data, base_din[31:0]};
                be_m  = {i_byteEnable, base_be[3:0]};
            end else begin
                din_m = {base_din[63:32], i_data};
                be_m  = {base_be[7:4], i_byteEnable};
            end
            rem_d     = take_rem;
            wr_lane_d = !take_lane;
            // Unfilled lanes keep be = 0, covering odd starts and short tails.
            if (take_lane || take_last) begin
                ddr_din_d = din_m;
                ddr_be_d  = be_m;
                ddr_we_d  = 1'b1;
                acc_din_d = '0;
                acc_be_d  = '0;
            end else begin
                acc_din_d = din_m;
                acc_be_d  = be_m;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q        <= ST_IDLE;
            rem_q          <= '0;
            wr_lane_q      <= 1'b0;
            acc_din_q      <= '0;
            acc_be_q       <= '0;
            ddr_we_q       <= 1'b0;
            ddr_din_q      <= '0;
            ddr_be_q       <= '0;
            ddr_addr_q     <= '0;
            ddr_burstcnt_q <= '0;
            ddr_rd_q       <= 1'b0;
            rd_lane_q      <= 1'b0;
            data_q         <= '0;
            data_vld_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            wr_lane_q      <= wr_lane_d;
            acc_din_q      <= acc_din_d;
            acc_be_q       <= acc_be_d;
            ddr_we_q       <= ddr_we_d;
            ddr_din_q      <= ddr_din_d;
            ddr_be_q       <= ddr_be_d;
            ddr_addr_q     <= ddr_addr_d;
            ddr_burstcnt_q <= ddr_burstcnt_d;
            ddr_rd_q       <= ddr_rd_d;
            rd_lane_q      <= rd_lane_d;
            data_q         <= data_d;
            data_vld_q     <= data_vld_d;
        end
    end

    assign o_busy         = busy;
    assign o_dataValid    = data_vld_q;
    assign o_data         = data_q;
    assign o_ddr_burstcnt = ddr_burstcnt_q;
    assign o_ddr_addr     = ddr_addr_q;
    assign o_ddr_din      = ddr_din_q;
    assign o_ddr_be       = ddr_be_q;
    assign o_ddr_we       = ddr_we_q;
    assign o_ddr_rd       = ddr_rd_q;

endmodule

// File: tb/tb_ddram_word_bridge.sv
// Purpose: directed self-checking bench for ddram_word_bridge (write packing, read unpacking, stalls, reset).
// Latency: n/a (testbench).
// Backpressure: drives i_ddr_busy stalls on write beats; read beats are never back-pressured.
module tb_ddram_word_bridge;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_writeEnable, i_readEnable;
    logic [7:0]  i_burstLength;
    logic [25:0] i_targetAddr;
    logic [31:0] i_data;
    logic [3:0]  i_byteEnable;
    logic        o_busy, o_dataValid;
    logic [31:0] o_data;
    logic [7:0]  o_ddr_burstcnt;
    logic [28:0] o_ddr_addr;
    logic [63:0] o_ddr_din;
    logic [7:0]  o_ddr_be;
    logic        o_ddr_we, o_ddr_rd;
    logic        i_ddr_busy;
    logic [63:0] i_ddr_dout;
    logic        i_ddr_dout_ready;

    always #5 i_clk = ~i_clk;

    ddram_word_bridge #(
        .ADDR_HI   (4'h3),
        .MAX_WORDS (32)
    ) dut (
        .i_clk            (i_clk),
        .i_nrst           (i_nrst),
        .i_writeEnable    (i_writeEnable),
        .i_readEnable     (i_readEnable),
        .i_burstLength    (i_burstLength),
        .i_targetAddr     (i_targetAddr),
        .i_data           (i_data),
        .i_byteEnable     (i_byteEnable),
        .o_busy           (o_busy),
        .o_dataValid      (o_dataValid),
        .o_data           (o_data),
        .o_ddr_burstcnt   (o_ddr_burstcnt),
        .o_ddr_addr       (o_ddr_addr),
        .o_ddr_din        (o_ddr_din),
        .o_ddr_be         (o_ddr_be),
        .o_ddr_we         (o_ddr_we),
        .o_ddr_rd         (o_ddr_rd),
        .i_ddr_busy       (i_ddr_busy),
        .i_ddr_dout       (i_ddr_dout),
        .i_ddr_dout_ready (i_ddr_dout_ready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] din;
        logic [7:0]  be;
        logic [28:0] addr;
        logic [7:0]  cnt;
        int          c;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        int          c;
        logic        busy;
    } word_t;

    beat_t       bq[$];
    word_t       wq[$];
    int          stall_seen = 0;
    int          stall_busy = 0;
    int          stall_chg = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] last_sdin = '0;
    logic [7:0]  last_sbe = '0;
    logic        prev_dv = 1'b0;
    logic        busy_after_dv = 1'b1;

    // Observes accepted write beats, write stalls and emitted read words at the falling edge.
    always @(negedge i_clk) begin
        if (i_nrst) begin
            if (o_ddr_we && !i_ddr_busy)
                bq.push_back('{o_ddr_din, o_ddr_be, o_ddr_addr, o_ddr_burstcnt, cyc});
            if (o_ddr_we && i_ddr_busy) begin
                stall_seen <= stall_seen + 1;
                if (o_busy) stall_busy <= stall_busy + 1;
                if (prev_stall && (o_ddr_din != last_sdin || o_ddr_be != last_sbe))
                    stall_chg <= stall_chg + 1;
                last_sdin <= o_ddr_din;
                last_sbe  <= o_ddr_be;
            end
            prev_stall <= o_ddr_we && i_ddr_busy;
            if (o_dataValid) wq.push_back('{o_data, cyc, o_busy});
            if (prev_dv && !o_dataValid) busy_after_dv <= o_busy;
            prev_dv <= o_dataValid;
        end else begin
            prev_stall <= 1'b0;
            prev_dv    <= 1'b0;
        end
    end

    function automatic beat_t beat_at(input int i);
        beat_t z;
        z = '{64'd0, 8'd0, 29'd0, 8'd0, -1};
        if (i < bq.size()) z = bq[i];
        return z;
    endfunction

    function automatic word_t word_at(input int i);
        word_t z;
        z = '{32'd0, -1, 1'b0};
        if (i < wq.size()) z = wq[i];
        return z;
    endfunction

    task automatic chk_beat(input string tag, input int idx, input logic [63:0] din,
                            input logic [63:0] mask, input logic [7:0] be,
                            input logic [28:0] addr, input logic [7:0] cnt);
        beat_t b;
        b = beat_at(idx);
        chk({tag, "_din"}, b.din & mask, din & mask);
        chk({tag, "_be"}, 64'(b.be), 64'(be));
        chk({tag, "_addr"}, 64'(b.addr), 64'(addr));
        chk({tag, "_cnt"}, 64'(b.cnt), 64'(cnt));
    endtask

    // Streams len words base, base+1, ... obeying o_busy; stalls the first `stall` cycles o_ddr_we is up.
    task automatic do_write(input logic [25:0] addr, input logic [7:0] len, input logic [31:0] base,
                            input int stall, output int start_cyc);
        int   i;
        int   guard;
        int   st;
        logic take;
        i = 0;
        guard = 0;
        st = stall;
        @(posedge i_clk); #1;
        start_cyc     = cyc;
        i_targetAddr  = addr;
        i_burstLength = len;
        i_byteEnable  = 4'hF;
        i_data        = base;
        i_writeEnable = 1'b1;
        i_ddr_busy    = 1'b0;
        while ((i < int'(len) || o_ddr_we) && guard < 60) begin
            @(negedge i_clk);
            take = i_writeEnable && !o_busy;
            @(posedge i_clk); #1;
            guard++;
            if (take) begin
                i++;
                i_data = base + 32'(i);
                if (i >= int'(len)) i_writeEnable = 1'b0;
            end
            if (st > 0 && o_ddr_we) begin
                i_ddr_busy = 1'b1;
                st--;
            end else begin
                i_ddr_busy = 1'b0;
            end
        end
        i_writeEnable = 1'b0;
        i_ddr_busy    = 1'b0;
        if (guard >= 60) chk("wr_timeout", 64'd1, 64'd0);
    endtask

    // Presents a read command for one cycle; returns at posedge+1 with the command accepted.
    task automatic rd_cmd(input logic [25:0] addr, input logic [7:0] len);
        @(posedge i_clk); #1;
        i_targetAddr  = addr;
        i_burstLength = len;
        i_readEnable  = 1'b1;
        @(posedge i_clk); #1;
        i_readEnable  = 1'b0;
    endtask

    task automatic feed_beat(input logic [63:0] d);
        i_ddr_dout       = d;
        i_ddr_dout_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ddr_dout_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (g < 100) begin
            @(negedge i_clk);
            if (!o_busy && !o_ddr_we && !o_ddr_rd) break;
            g++;
        end
        if (g >= 100) chk("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n0;
        int b0;
        int w0;
        int ss, sb, sc;
        int bad;
        word_t w;
        i_nrst = 1'b0;
        i_writeEnable = 1'b0;
        i_readEnable = 1'b0;
        i_burstLength = 8'd0;
        i_targetAddr = '0;
        i_data = '0;
        i_byteEnable = '0;
        i_ddr_busy = 1'b0;
        i_ddr_dout = '0;
        i_ddr_dout_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_dv", 64'(o_dataValid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_we", 64'(o_ddr_we), 64'd0);
        chk("rst_rd", 64'(o_ddr_rd), 64'd0);
        chk("rst_addr", 64'(o_ddr_addr), 64'd0);
        chk("rst_cnt", 64'(o_ddr_burstcnt), 64'd0);
        chk("rst_din", o_ddr_din, 64'd0);
        chk("rst_be", 64'(o_ddr_be), 64'd0);
        @(posedge i_clk); #1;
        i_nrst = 1'b1;

        // Length 0 is ignored
        @(posedge i_clk); #1;
        i_writeEnable = 1'b1;
        i_readEnable = 1'b1;
        i_burstLength = 8'd0;
        i_targetAddr = 26'h10;
        @(negedge i_clk);
        chk("len0_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
        i_writeEnable = 1'b0;
        i_readEnable = 1'b0;
        @(negedge i_clk);
        chk("len0_we", 64'(o_ddr_we), 64'd0);
        chk("len0_rd", 64'(o_ddr_rd), 64'd0);

        // Write addr 0x10 len 4: {A1,A0},{A3,A2}
        b0 = bq.size();
        do_write(26'h10, 8'd4, 32'hA000_0000, 0, s);
        chk("w4_nbeats", 64'(bq.size() - b0), 64'd2);
        chk_beat("w4_b0", b0, 64'hA0000001_A0000000, '1, 8'hFF, 29'h0600_0008, 8'd2);
        chk_beat("w4_b1", b0 + 1, 64'hA0000003_A0000002, '1, 8'hFF, 29'h0600_0008, 8'd2);
        chk("w4_b0_cyc", 64'(beat_at(b0).c), 64'(s + 2));
        chk("w4_b1_cyc", 64'(beat_at(b0 + 1).c), 64'(s + 4));

        // Write odd addr 0x11 len 2: A0 upper lane, then A1 lower lane
        b0 = bq.size();
        do_write(26'h11, 8'd2, 32'hA100_0000, 0, s);
        chk("w2odd_nbeats", 64'(bq.size() - b0), 64'd2);
        chk_beat("w2odd_b0", b0, 64'hA1000000_00000000, 64'hFFFFFFFF_00000000, 8'hF0, 29'h0600_0008, 8'd2);
        chk_beat("w2odd_b1", b0 + 1, 64'h00000000_A1000001, 64'h00000000_FFFFFFFF, 8'h0F, 29'h0600_0008, 8'd2);
        chk("w2odd_b0_cyc", 64'(beat_at(b0).c), 64'(s + 1));

        // Single-word write at even addr 0x30
        b0 = bq.size();
        do_write(26'h30, 8'd1, 32'hA200_0000, 0, s);
        chk("w1_nbeats", 64'(bq.size() - b0), 64'd1);
        chk_beat("w1_b0", b0, 64'h00000000_A2000000, 64'h00000000_FFFFFFFF, 8'h0F, 29'h0600_0018, 8'd1);
        chk("w1_b0_cyc", 64'(beat_at(b0).c), 64'(s + 1));

        // Write with 5 stall cycles on the first beat
        b0 = bq.size();
        ss = stall_seen;
        sb = stall_busy;
        sc = stall_chg;
        do_write(26'h20, 8'd4, 32'hD000_0000, 5, s);
        chk("stall_cycles", 64'(stall_seen - ss), 64'd5);
        chk("stall_busy", 64'(stall_busy - sb), 64'd5);
        chk("stall_stable", 64'(stall_chg - sc), 64'd0);
        chk("stall_nbeats", 64'(bq.size() - b0), 64'd2);
        chk_beat("stall_b0", b0, 64'hD0000001_D0000000, '1, 8'hFF, 29'h0600_0010, 8'd2);
        chk_beat("stall_b1", b0 + 1, 64'hD0000003_D0000002, '1, 8'hFF, 29'h0600_0010, 8'd2);

        // Read addr 3 len 3: beats {B1,B0},{B3,B2} -> B1,B2,B3
        w0 = wq.size();
        @(posedge i_clk); #1;
        i_targetAddr = 26'h3;
        i_burstLength = 8'd3;
        i_readEnable = 1'b1;
        @(negedge i_clk);
        chk("r3_accept_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
        i_readEnable = 1'b0;
        @(negedge i_clk);
        chk("r3_rd", 64'(o_ddr_rd), 64'd1);
        chk("r3_cnt", 64'(o_ddr_burstcnt), 64'd2);
        chk("r3_addr", 64'(o_ddr_addr), 64'h0600_0001);
        chk("r3_busy_cmd", 64'(o_busy), 64'd1);
        @(posedge i_clk); #1;
        n0 = cyc;
        feed_beat(64'hB0000001_B0000000);
        feed_beat(64'hB0000003_B0000002);
        wait_idle();
        chk("r3_nwords", 64'(wq.size() - w0), 64'd3);
        chk("r3_w0", 64'(word_at(w0).d), 64'hB000_0001);
        chk("r3_w1", 64'(word_at(w0 + 1).d), 64'hB000_0002);
        chk("r3_w2", 64'(word_at(w0 + 2).d), 64'hB000_0003);
        chk("r3_w0_cyc", 64'(word_at(w0).c), 64'(n0 + 2));
        chk("r3_w2_cyc", 64'(word_at(w0 + 2).c), 64'(n0 + 4));
        chk("r3_busy_last", 64'(word_at(w0 + 2).busy), 64'd1);
        chk("r3_busy_after", 64'(busy_after_dv), 64'd0);

        // Read addr 0x40 len 32: 16 back-to-back beats
        w0 = wq.size();
        rd_cmd(26'h40, 8'd32);
        @(negedge i_clk);
        chk("r32_cnt", 64'(o_ddr_burstcnt), 64'd16);
        chk("r32_addr", 64'(o_ddr_addr), 64'h0600_0020);
        @(posedge i_clk); #1;
        for (int k = 0; k < 16; k++)
            feed_beat({32'hC000_0000 + 32'(2 * k + 1), 32'hC000_0000 + 32'(2 * k)});
        wait_idle();
        chk("r32_nwords", 64'(wq.size() - w0), 64'd32);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            w = word_at(w0 + k);
            if (w.d !== 32'hC000_0000 + 32'(k)) bad++;
            if (k > 0 && w.c != word_at(w0 + k - 1).c + 1) bad++;
        end
        chk("r32_order", 64'(bad), 64'd0);

        // Reset during RD_DATA after 3 of 4 beats
        rd_cmd(26'h80, 8'd8);
        @(negedge i_clk);
        @(posedge i_clk); #1;
        feed_beat(64'h50000001_50000000);
        feed_beat(64'h50000003_50000002);
        feed_beat(64'h50000005_50000004);
        i_nrst = 1'b0;
        #2;
        chk("mrst_busy", 64'(o_busy), 64'd0);
        chk("mrst_dv", 64'(o_dataValid), 64'd0);
        chk("mrst_data", 64'(o_data), 64'd0);
        chk("mrst_rd", 64'(o_ddr_rd), 64'd0);
        chk("mrst_addr", 64'(o_ddr_addr), 64'd0);
        chk("mrst_cnt", 64'(o_ddr_burstcnt), 64'd0);
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        w0 = wq.size();
        feed_beat(64'h50000007_50000006);
        repeat (6) @(negedge i_clk);
        chk("mrst_no_dv", 64'(wq.size() - w0), 64'd0);
        chk("mrst_idle", 64'(o_busy), 64'd0);
        b0 = bq.size();
        do_write(26'h10, 8'd2, 32'hE000_0000, 0, s);
        chk("mrst_w_nbeats", 64'(bq.size() - b0), 64'd1);
        chk_beat("mrst_w_b0", b0, 64'hE0000001_E0000000, '1, 8'hFF, 29'h0600_0008, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
